// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule constants, K table, small-sigma helpers
// and the message-schedule state encoding.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int WIN    = 16;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotate by shifting a doubled copy; the low half is the rotated word.
    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w_dbl;
        w_dbl = {x, x} >> n;
        return w_dbl[31:0];
    endfunction

    function automatic logic [31:0] sigma0_small(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 5'd3);
    endfunction

    function automatic logic [31:0] sigma1_small(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 5'd10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant ROM, shared by the schedule and round stages.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  i_addr,
    output logic [31:0] o_k
);

    assign o_k = K_TABLE[i_addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W[t]/K[t] for t = 0..63
// from a 16-word sliding window expanded in place.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_w,
    output logic [DATA_W-1:0] out_k,
    output logic [5:0]        out_round,
    output logic              out_last
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_load_cnt;
    logic [5:0]        r_round;
    logic [DATA_W-1:0] r_win [WIN];
    logic [DATA_W-1:0] w_new_word;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last;
    logic              w_load_done;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_last      = (r_round == LAST_ROUND);
    assign w_load_done = w_in_fire & (r_load_cnt == 4'd15);
    // Window holds W[t..t+15]; this produces W[t+16].
    assign w_new_word  = sigma1_small(r_win[14]) + r_win[9] + sigma0_small(r_win[1]) + r_win[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst || run) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_load_done) w_state_nxt = ST_EMIT;
                else             w_state_nxt = ST_LOAD;
            end
            ST_EMIT: begin
                if (w_out_fire && w_last) w_state_nxt = ST_LOAD;
                else                      w_state_nxt = ST_EMIT;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_LOAD: in_ready  = 1'b1;
            ST_EMIT: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Window, load counter and round counter; counters wrap to 0 on leaving each state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt <= 4'd0;
            r_round    <= 6'd0;
            for (int i = 0; i < WIN; i++) r_win[i] <= '0;
        end else if (run) begin
            r_load_cnt <= 4'd0;
            r_round    <= 6'd0;
        end else if (w_in_fire) begin
            for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
            r_win[WIN-1] <= in_data;
            r_load_cnt   <= r_load_cnt + 4'd1;
            r_round      <= 6'd0;
        end else if (w_out_fire) begin
            for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
            r_win[WIN-1] <= w_new_word;
            r_round      <= r_round + 6'd1;
        end else begin
            r_load_cnt <= r_load_cnt;
            r_round    <= r_round;
        end
    end

    sha256_k_rom u_k_rom (
        .i_addr (r_round),
        .o_k    (out_k)
    );

    assign out_w     = r_win[0];
    assign out_round = r_round;
    assign out_last  = out_valid & w_last;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed/randomized bench for sha256_msg_schedule against a plain-arithmetic
// FIPS 180-4 schedule model.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst, run, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_data, out_w, out_k;
    logic [5:0]  out_round;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] msg  [16];
    logic [31:0] wexp [64];
    logic [31:0] got  [64];

    localparam logic [31:0] KREF [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    always #5 clk = ~clk;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_k     (out_k),
        .out_round (out_round),
        .out_last  (out_last)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic expand();
        for (int t = 0; t < 16; t++) wexp[t] = msg[t];
        for (int t = 16; t < 64; t++)
            wexp[t] = ref_s1(wexp[t-2]) + wexp[t-7] + ref_s0(wexp[t-15]) + wexp[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        expand();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom();
        expand();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_round"},     32'(out_round), 32'd0);
        chk({tag, "_last"},      32'(out_last),  32'd0);
        chk({tag, "_k"},         out_k,          32'h428a2f98);
    endtask

    // Feed the first nwords of msg with gap_pct percent idle cycles.
    task automatic load_block(input int nwords, input int gap_pct);
        int i   = 0;
        int cyc = 0;
        while (i < nwords && cyc < 2000) begin
            in_valid  = ($urandom_range(99) < 32'(gap_pct)) ? 1'b0 : 1'b1;
            in_data   = in_valid ? msg[i] : $urandom();
            out_ready = 1'($urandom_range(1));
            chk("load_in_ready",  32'(in_ready),  32'd1);
            chk("load_out_valid", 32'(out_valid), 32'd0);
            tick();
            if (in_valid) i++;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < nwords) chk("load_timeout", 32'(i), 32'(nwords));
    endtask

    // Collect handshakes until stop_round pairs have been accepted.
    task automatic emit_block(input bit bp, input int stop_round);
        int          t       = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        logic [31:0] hw, hk;
        logic [5:0]  hr;
        while (t < stop_round && cyc < 4000) begin
            out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
            in_valid  = 1'($urandom_range(1));
            in_data   = $urandom();
            chk("emit_out_valid", 32'(out_valid), 32'd1);
            chk("emit_in_ready",  32'(in_ready),  32'd0);
            if (stalled) begin
                chk("hold_w",     out_w,          hw);
                chk("hold_k",     out_k,          hk);
                chk("hold_round", 32'(out_round), 32'(hr));
            end
            if (out_ready) begin
                chk("w",     out_w,          wexp[t]);
                chk("k",     out_k,          KREF[t]);
                chk("round", 32'(out_round), 32'(t));
                chk("last",  32'(out_last),  (t == 63) ? 32'd1 : 32'd0);
                got[t] = out_w;
            end
            hw = out_w;
            hk = out_k;
            hr = out_round;
            stalled = !out_ready;
            tick();
            if (out_ready) t++;
            cyc++;
        end
        in_valid = 1'b0;
        if (t < stop_round) chk("emit_timeout", 32'(t), 32'(stop_round));
        if (stop_round == 64) chk_idle("after_last");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        run       = 1'($urandom_range(1));
        in_valid  = 1'($urandom_range(1));
        in_data   = $urandom();
        out_ready = 1'($urandom_range(1));
        tick();
        run       = 1'($urandom_range(1));
        in_valid  = 1'($urandom_range(1));
        in_data   = $urandom();
        out_ready = 1'($urandom_range(1));
        tick();
        chk_idle("reset");
        chk("reset_w", out_w, 32'h0);
        rst       = 1'b0;
        run       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        // "abc" block, no backpressure
        set_abc();
        load_block(16, 0);
        emit_block(1'b0, 64);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);
        chk("abc_w18", got[18], 32'h7DA86405);
        chk("abc_w19", got[19], 32'h600003C6);
        chk("abc_w20", got[20], 32'h3E9D7B78);
        chk("abc_w21", got[21], 32'h0183FC00);

        // "abc" with input gaps and random backpressure
        load_block(16, 40);
        emit_block(1'b1, 64);

        // Back-to-back random blocks
        set_random();
        load_block(16, 0);
        emit_block(1'b0, 64);
        set_random();
        load_block(16, 0);
        emit_block(1'b0, 64);

        // Abort at round 30 with a concurrent handshake
        set_abc();
        load_block(16, 0);
        emit_block(1'b0, 30);
        run       = 1'b1;
        out_ready = 1'b1;
        tick();
        run = 1'b0;
        chk_idle("abort_emit");

        // Abort at load count 7 with a concurrent input word
        set_random();
        load_block(7, 0);
        run      = 1'b1;
        in_valid = 1'b1;
        in_data  = $urandom();
        tick();
        run      = 1'b0;
        in_valid = 1'b0;
        chk_idle("abort_load");
        set_random();
        load_block(16, 20);
        emit_block(1'b1, 64);

        // Reset in the middle of emission
        set_random();
        load_block(16, 0);
        emit_block(1'b0, 40);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_emit");
        chk("rst_emit_w", out_w, 32'h0);
        set_random();
        load_block(16, 0);
        emit_block(1'b0, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
